// File: rtl/inst_fetch.sv
// inst_fetch: PC generator feeding a circular instruction queue.
// Hits enqueue {pc, inst}; a flush redirects the PC and empties the queue.
module inst_fetch #(
   parameter int unsigned QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic [31:0] if_icache_inst_addr_out,
   input  logic        icache_if_miss_in,
   input  logic [31:0] icache_if_inst_inst_in,
   output logic        if_dec_valid_out,
   output logic [31:0] if_dec_inst_out,
   output logic [31:0] if_dec_pc_out,
   input  logic        dec_if_ready_in,
   input  logic        rob_if_flush_in,
   input  logic [31:0] rob_if_flush_pc_in
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(QDEPTH);
   localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

   logic [31:0]   pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   q_pc   [QDEPTH];
   logic [31:0]   q_inst [QDEPTH];

   logic flush;
   logic pop;
   logic push;

   assign flush = rdy_in && rob_if_flush_in;

   assign if_dec_valid_out = (count != '0) && !rob_if_flush_in;
   assign if_dec_pc_out    = q_pc[head];
   assign if_dec_inst_out  = q_inst[head];

   assign pop  = rdy_in && if_dec_valid_out && dec_if_ready_in;
   // A pop in the same cycle frees the slot, so a full queue still streams.
   assign push = rdy_in && !rob_if_flush_in && !icache_if_miss_in
                 && ((count < FULL) || pop);

   assign if_icache_inst_addr_out = pc;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc    <= RST_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         pc    <= rob_if_flush_pc_in & ~32'h3;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            pc   <= pc + 32'd4;
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk_in) begin
      if (push) begin
         q_pc[tail]   <= pc;
         q_inst[tail] <= icache_if_inst_inst_in;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch.
// The i-cache model returns a word derived from the fetch address.
module tb_inst_fetch;

   localparam int QD = 4;
   localparam logic [31:0] RPC = 32'h0;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic [31:0] addr;
   logic        miss = 1'b0;
   logic [31:0] inst_in;
   logic        valid;
   logic [31:0] d_inst;
   logic [31:0] d_pc;
   logic        dec_rdy = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   assign inst_in = word(addr);

   always #5 clk_in = ~clk_in;

   inst_fetch #(
      .QDEPTH  (QD),
      .RESET_PC(RPC)
   ) dut (
      .clk_in                 (clk_in),
      .rst_in                 (rst_in),
      .rdy_in                 (rdy_in),
      .if_icache_inst_addr_out(addr),
      .icache_if_miss_in      (miss),
      .icache_if_inst_inst_in (inst_in),
      .if_dec_valid_out       (valid),
      .if_dec_inst_out        (d_inst),
      .if_dec_pc_out          (d_pc),
      .dec_if_ready_in        (dec_rdy),
      .rob_if_flush_in        (flush),
      .rob_if_flush_pc_in     (flush_pc)
   );

   task automatic do_reset();
      rst_in   = 1'b1;
      rdy_in   = 1'b1;
      miss     = 1'b0;
      dec_rdy  = 1'b1;
      flush    = 1'b0;
      flush_pc = 32'h0;
      exp_q.delete();
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in  = 1'b1;
      rdy_in  = 1'b1;
      dec_rdy = 1'b1;
      miss    = 1'b0;
      repeat (2) @(negedge clk_in);
      #1;
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_valid got %b want 0", valid);
      end
      n_vec++;
      if (addr !== RPC) begin
         n_err++;
         $display("FAIL reset_addr got %h want %h", addr, RPC);
      end
   endtask

   task automatic test_stream();
      ent_t e;
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         a = 32'(4 * i);
         exp_q.push_back('{a, word(a)});
      end
      for (int c = 0; c <= 12; c++) begin
         #1;
         n_vec++;
         if (addr !== 32'(4 * c)) begin
            n_err++;
            $display("FAIL stream_addr c=%0d got %h want %h",
                     c, addr, 32'(4 * c));
         end
         n_vec++;
         if (valid !== (c != 0)) begin
            n_err++;
            $display("FAIL stream_valid c=%0d got %b want %b",
                     c, valid, (c != 0));
         end
         if (valid && rdy_in && dec_rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stream_under got pc %h want none", d_pc);
            end else begin
               e = exp_q.pop_front();
               if (d_pc !== e.pc || d_inst !== e.inst) begin
                  n_err++;
                  $display("FAIL stream_head got %h/%h want %h/%h",
                           d_pc, d_inst, e.pc, e.inst);
               end
            end
         end
         @(negedge clk_in);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL stream_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_fill();
      ent_t e;
      logic [31:0] a;
      do_reset();
      dec_rdy = 1'b0;
      for (int c = 0; c < 10; c++) begin
         a = (c < 4) ? 32'(4 * c) : 32'h10;
         #1;
         n_vec++;
         if (addr !== a) begin
            n_err++;
            $display("FAIL fill_addr c=%0d got %h want %h", c, addr, a);
         end
         n_vec++;
         if (valid !== (c != 0)) begin
            n_err++;
            $display("FAIL fill_valid c=%0d got %b", c, valid);
         end
         @(negedge clk_in);
      end
      dec_rdy = 1'b1;
      for (int i = 0; i < 7; i++) begin
         a = 32'(4 * i);
         exp_q.push_back('{a, word(a)});
      end
      for (int k = 0; k < 7; k++) begin
         #1;
         n_vec++;
         if (addr !== 32'h10 + 32'(4 * k)) begin
            n_err++;
            $display("FAIL drain_addr k=%0d got %h want %h",
                     k, addr, 32'h10 + 32'(4 * k));
         end
         n_vec++;
         if (valid !== 1'b1) begin
            n_err++;
            $display("FAIL drain_valid k=%0d got %b want 1", k, valid);
         end
         if (valid && rdy_in && dec_rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL drain_under got pc %h want none", d_pc);
            end else begin
               e = exp_q.pop_front();
               if (d_pc !== e.pc || d_inst !== e.inst) begin
                  n_err++;
                  $display("FAIL drain_head got %h/%h want %h/%h",
                           d_pc, d_inst, e.pc, e.inst);
               end
            end
         end
         @(negedge clk_in);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_miss();
      ent_t e;
      logic [31:0] a;
      logic        v;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = 32'(4 * i);
         exp_q.push_back('{a, word(a)});
      end
      for (int c = 0; c <= 8; c++) begin
         miss = (c >= 2 && c <= 6);
         a = (c <= 2) ? 32'(4 * c) : ((c <= 7) ? 32'h8 : 32'hC);
         v = (c == 1 || c == 2 || c == 8);
         #1;
         n_vec++;
         if (addr !== a) begin
            n_err++;
            $display("FAIL miss_addr c=%0d got %h want %h", c, addr, a);
         end
         n_vec++;
         if (valid !== v) begin
            n_err++;
            $display("FAIL miss_valid c=%0d got %b want %b", c, valid, v);
         end
         if (valid && rdy_in && dec_rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL miss_under got pc %h want none", d_pc);
            end else begin
               e = exp_q.pop_front();
               if (d_pc !== e.pc || d_inst !== e.inst) begin
                  n_err++;
                  $display("FAIL miss_head got %h/%h want %h/%h",
                           d_pc, d_inst, e.pc, e.inst);
               end
            end
         end
         @(negedge clk_in);
      end
      miss = 1'b0;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL miss_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_flush_full();
      ent_t e;
      do_reset();
      dec_rdy = 1'b0;
      repeat (6) @(negedge clk_in);
      #1;
      n_vec++;
      if (addr !== 32'h10 || valid !== 1'b1) begin
         n_err++;
         $display("FAIL ff_full got %h/%b want 00000010/1", addr, valid);
      end
      dec_rdy  = 1'b1;
      flush    = 1'b1;
      flush_pc = 32'h1003;
      #1;
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL ff_mask got %b want 0", valid);
      end
      @(negedge clk_in);
      flush = 1'b0;
      exp_q.push_back('{32'h1000, word(32'h1000)});
      exp_q.push_back('{32'h1004, word(32'h1004)});
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_vec++;
         if (addr !== 32'h1000 + 32'(4 * (k - 1))) begin
            n_err++;
            $display("FAIL ff_addr k=%0d got %h want %h",
                     k, addr, 32'h1000 + 32'(4 * (k - 1)));
         end
         n_vec++;
         if (valid !== (k >= 2)) begin
            n_err++;
            $display("FAIL ff_valid k=%0d got %b want %b",
                     k, valid, (k >= 2));
         end
         if (valid && rdy_in && dec_rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL ff_under got pc %h want none", d_pc);
            end else begin
               e = exp_q.pop_front();
               if (d_pc !== e.pc || d_inst !== e.inst) begin
                  n_err++;
                  $display("FAIL ff_head got %h/%h want %h/%h",
                           d_pc, d_inst, e.pc, e.inst);
               end
            end
         end
         @(negedge clk_in);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ff_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_rdy_freeze();
      ent_t e;
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = 32'(4 * i);
         exp_q.push_back('{a, word(a)});
      end
      for (int c = 0; c <= 2; c++) begin
         #1;
         n_vec++;
         if (addr !== 32'(4 * c) || valid !== (c != 0)) begin
            n_err++;
            $display("FAIL frz_pre c=%0d got %h/%b", c, addr, valid);
         end
         if (valid && rdy_in && dec_rdy) begin
            e = exp_q.pop_front();
            n_vec++;
            if (d_pc !== e.pc || d_inst !== e.inst) begin
               n_err++;
               $display("FAIL frz_head got %h/%h want %h/%h",
                        d_pc, d_inst, e.pc, e.inst);
            end
         end
         @(negedge clk_in);
      end
      rdy_in   = 1'b0;
      flush    = 1'b1;
      flush_pc = 32'h2000;
      for (int c = 3; c <= 5; c++) begin
         #1;
         n_vec++;
         if (addr !== 32'hC || valid !== 1'b0) begin
            n_err++;
            $display("FAIL frz_hold c=%0d got %h/%b want 0000000c/0",
                     c, addr, valid);
         end
         @(negedge clk_in);
      end
      flush = 1'b0;
      #1;
      n_vec++;
      if (valid !== 1'b1 || d_pc !== exp_q[0].pc || addr !== 32'hC) begin
         n_err++;
         $display("FAIL frz_state got %b/%h/%h want 1/%h/0000000c",
                  valid, d_pc, addr, exp_q[0].pc);
      end
      @(negedge clk_in);
      rdy_in = 1'b1;
      flush  = 1'b1;
      #1;
      n_vec++;
      if (addr !== 32'hC || valid !== 1'b0) begin
         n_err++;
         $display("FAIL frz_fl got %h/%b want 0000000c/0", addr, valid);
      end
      exp_q.delete();
      exp_q.push_back('{32'h2000, word(32'h2000)});
      @(negedge clk_in);
      flush = 1'b0;
      #1;
      n_vec++;
      if (addr !== 32'h2000 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL frz_redir got %h/%b want 00002000/0", addr, valid);
      end
      @(negedge clk_in);
      #1;
      n_vec++;
      if (valid !== 1'b1) begin
         n_err++;
         $display("FAIL frz_valid got %b want 1", valid);
      end else begin
         e = exp_q.pop_front();
         if (d_pc !== e.pc || d_inst !== e.inst) begin
            n_err++;
            $display("FAIL frz_new got %h/%h want %h/%h",
                     d_pc, d_inst, e.pc, e.inst);
         end
      end
      @(negedge clk_in);
   endtask

   task automatic test_async_reset();
      ent_t e;
      do_reset();
      dec_rdy = 1'b0;
      repeat (3) @(negedge clk_in);
      miss = 1'b1;
      #1;
      n_vec++;
      if (valid !== 1'b1 || addr !== 32'hC) begin
         n_err++;
         $display("FAIL ar_pre got %b/%h want 1/0000000c", valid, addr);
      end
      #1;
      rst_in = 1'b1;
      #1;
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL ar_valid got %b want 0", valid);
      end
      n_vec++;
      if (addr !== RPC) begin
         n_err++;
         $display("FAIL ar_addr got %h want %h", addr, RPC);
      end
      @(negedge clk_in);
      rst_in  = 1'b0;
      miss    = 1'b0;
      dec_rdy = 1'b1;
      exp_q.push_back('{32'h0, word(32'h0)});
      exp_q.push_back('{32'h4, word(32'h4)});
      for (int c = 0; c <= 2; c++) begin
         #1;
         n_vec++;
         if (valid !== (c != 0)) begin
            n_err++;
            $display("FAIL ar_post c=%0d got %b want %b",
                     c, valid, (c != 0));
         end
         if (valid && rdy_in && dec_rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL ar_under got pc %h want none", d_pc);
            end else begin
               e = exp_q.pop_front();
               if (d_pc !== e.pc || d_inst !== e.inst) begin
                  n_err++;
                  $display("FAIL ar_head got %h/%h want %h/%h",
                           d_pc, d_inst, e.pc, e.inst);
               end
            end
         end
         @(negedge clk_in);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill();
      test_miss();
      test_flush_full();
      test_rdy_freeze();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
